// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if
//   Bundles the control and status signals of the CPU run/step/burst
//   sequencer. The master side (host or bench) drives the mode and
//   configuration signals; the slave side (cpu_run_ctrl) returns the core
//   clock enable, the memory-phase strobe and the status flags.
// Signals
//   mode[1:0]             00 halt, 01 run, 10 step, 11 burst
//   start                 one-cycle launch pulse
//   step_btn              raw asynchronous push-button
//   burst_len[CNT_W-1:0]  enables issued per burst, sampled on start
//   div_val[DIV_W-1:0]    clk cycles per cpu_ce (0 and 1 mean every cycle)
//   bp_en, bp_addr        breakpoint enable and address
//   cpu_pc                current core PC
//   cpu_ce                one-cycle core clock enable
//   phase_strobe          one-cycle strobe at half period
//   halted, bp_hit        status flags
//   cycle_count[31:0]     number of cpu_ce pulses issued
interface cpu_run_ctrl_if #(
  parameter int DIV_W = 32,
  parameter int PC_W  = 16,
  parameter int CNT_W = 16
);
  logic [1:0]       mode;
  logic             start;
  logic             step_btn;
  logic [CNT_W-1:0] burst_len;
  logic [DIV_W-1:0] div_val;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  cpu_pc;
  logic             cpu_ce;
  logic             phase_strobe;
  logic             halted;
  logic             bp_hit;
  logic [31:0]      cycle_count;

  modport master (
    output mode, start, step_btn, burst_len, div_val, bp_en, bp_addr, cpu_pc,
    input  cpu_ce, phase_strobe, halted, bp_hit, cycle_count
  );

  modport slave (
    input  mode, start, step_btn, burst_len, div_val, bp_en, bp_addr, cpu_pc,
    output cpu_ce, phase_strobe, halted, bp_hit, cycle_count
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
//   Run/step/burst sequencer for the CPU core clock. Divides the board clock
//   into one-cycle core enables (cpu_ce) with a mid-period memory strobe, and
//   supports free-run, debounced single-step, N-cycle burst and a PC
//   breakpoint halt.
// Ports
//   clk  board clock, all logic on posedge
//   rst  asynchronous active-low reset
//   bus  cpu_run_ctrl_if slave modport (mode/config in, enables/status out)
module cpu_run_ctrl #(
  parameter int DIV_W      = 32,
  parameter int DEB_CYCLES = 50000,
  parameter int PC_W       = 16,
  parameter int CNT_W      = 16
) (
  input logic           clk,
  input logic           rst,
  cpu_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_HALT, S_RUN, S_BURST, S_STEP} state_t;

  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  localparam int              DEB_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [CNT_W-1:0] remaining;
  logic             skip_bp;
  logic             step_req;

  logic             sync_a;
  logic             sync_b;
  logic [DEB_W-1:0] stable_cnt;
  logic             deb_level;
  logic             deb_rise;

  logic             cpu_ce_q;
  logic             strobe_q;
  logic             halted_q;
  logic             bp_hit_q;
  logic [31:0]      cycle_count_q;

  logic [DIV_W-1:0] div_eff;
  logic             tick;
  logic             strobe_point;
  logic             bp_match;
  logic             mode_held;

  // A divider value of 0 behaves like 1. The >= compare lets a divider that
  // shrinks below the current count fire on the very next cycle.
  always_comb begin
    div_eff      = (bus.div_val == '0) ? DIV_W'(1) : bus.div_val;
    tick         = (cnt >= (div_eff - DIV_W'(1)));
    strobe_point = (div_eff >= DIV_W'(4)) && (cnt == (div_eff >> 1));
    bp_match     = bus.bp_en && (bus.cpu_pc == bus.bp_addr) && !skip_bp;
    mode_held    = ((state == S_RUN)   && (bus.mode == MODE_RUN)) ||
                   ((state == S_BURST) && (bus.mode == MODE_BURST));
  end

  // Button path: two-flop synchroniser, then the debounced level only flips
  // after DEB_CYCLES consecutive samples disagreeing with it. A rising flip
  // produces a one-cycle request pulse for the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a     <= 1'b0;
      sync_b     <= 1'b0;
      stable_cnt <= '0;
      deb_level  <= 1'b0;
      deb_rise   <= 1'b0;
    end else begin
      sync_a   <= bus.step_btn;
      sync_b   <= sync_a;
      deb_rise <= 1'b0;
      if (sync_b == deb_level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == DEB_LAST) begin
        stable_cnt <= '0;
        deb_level  <= sync_b;
        deb_rise   <= sync_b;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

  // Sequencer FSM with registered outputs. The divider count is held at zero
  // in HALT so every launch waits a full period before its first enable.
  // Leaving RUN/BURST because of a mode change never emits a final enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_HALT;
      cnt           <= '0;
      remaining     <= '0;
      skip_bp       <= 1'b0;
      step_req      <= 1'b0;
      cpu_ce_q      <= 1'b0;
      strobe_q      <= 1'b0;
      halted_q      <= 1'b1;
      bp_hit_q      <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      cpu_ce_q <= 1'b0;
      strobe_q <= 1'b0;
      halted_q <= (state == S_HALT);

      // A step request only survives while step mode is selected.
      if (bus.mode != MODE_STEP) begin
        step_req <= 1'b0;
      end else if (deb_rise) begin
        step_req <= 1'b1;
      end

      case (state)
        S_HALT: begin
          cnt <= '0;
          if (bus.start) begin
            bp_hit_q <= 1'b0;
            skip_bp  <= 1'b1;
          end
          if (bus.start && (bus.mode == MODE_RUN)) begin
            state <= S_RUN;
          end else if (bus.start && (bus.mode == MODE_BURST) && (bus.burst_len != '0)) begin
            state     <= S_BURST;
            remaining <= bus.burst_len;
          end else if ((bus.mode == MODE_STEP) && step_req) begin
            state    <= S_STEP;
            step_req <= 1'b0;
          end
        end

        S_RUN, S_BURST: begin
          if (!mode_held) begin
            state <= S_HALT;
            cnt   <= '0;
          end else begin
            strobe_q <= strobe_point;
            if (tick) begin
              cnt <= '0;
              if (bp_match) begin
                bp_hit_q <= 1'b1;
                state    <= S_HALT;
              end else begin
                cpu_ce_q      <= 1'b1;
                cycle_count_q <= cycle_count_q + 32'd1;
                skip_bp       <= 1'b0;
                if (state == S_BURST) begin
                  remaining <= remaining - 1'b1;
                  if (remaining == CNT_W'(1)) begin
                    state <= S_HALT;
                  end
                end
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        S_STEP: begin
          if (tick) begin
            cnt           <= '0;
            cpu_ce_q      <= 1'b1;
            cycle_count_q <= cycle_count_q + 32'd1;
            skip_bp       <= 1'b0;
            state         <= S_HALT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= S_HALT;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.cpu_ce       = cpu_ce_q;
  assign bus.phase_strobe = strobe_q;
  assign bus.halted       = halted_q;
  assign bus.bp_hit       = bp_hit_q;
  assign bus.cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl
//   Self-checking bench for cpu_run_ctrl. Enable and strobe timestamps are
//   collected by a monitor and compared against times computed from the
//   divider rules (enable k at t0 + k*div, strobe at t0 + 1 + div/2 +
//   (k-1)*div), using a vector table, hand-written corner sequences and
//   randomized run/burst transactions.
module tb_cpu_run_ctrl;

  localparam int DIV_W = 32;
  localparam int PC_W  = 16;
  localparam int CNT_W = 16;
  localparam int DEB   = 8;

  localparam logic [1:0] M_HALT  = 2'b00;
  localparam logic [1:0] M_RUN   = 2'b01;
  localparam logic [1:0] M_STEP  = 2'b10;
  localparam logic [1:0] M_BURST = 2'b11;

  typedef struct {
    logic [1:0] mode;
    int         div;
    int         len;
    int         w;
    int         exp_n;
    int         exp_s;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  int              cyc = 0;
  int              total = 0;
  int              bad = 0;
  int              exp_cc = 0;
  int              ce_total = 0;
  int              pc_ref = 0;
  logic [PC_W-1:0] pc_start = '0;
  int              ce_q[$];
  int              st_q[$];
  int              exp_ce[$];
  int              exp_st[$];
  vec_t            vecs[10];

  cpu_run_ctrl_if #(.DIV_W(DIV_W), .PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  cpu_run_ctrl #(
    .DIV_W(DIV_W), .DEB_CYCLES(DEB), .PC_W(PC_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // The fake core advances its PC by one for every enable it receives.
  assign bus.cpu_pc = pc_start + PC_W'(ce_total - pc_ref);

  always @(negedge clk) begin
    if (bus.cpu_ce) begin
      ce_total++;
      ce_q.push_back(cyc);
    end
    if (bus.phase_strobe) st_q.push_back(cyc);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input longint got, input longint expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] mode, input int d, input int len);
    bus.mode      = mode;
    bus.div_val   = DIV_W'(d);
    bus.burst_len = CNT_W'(len);
  endtask

  task automatic pulse_start(output int t0);
    bus.start = 1'b1;
    t0 = cyc + 1;
    wait_cycles(1);
    bus.start = 1'b0;
  endtask

  function automatic int ce_at(input int i, input int t0);
    return (i < ce_q.size()) ? ce_q[i] - t0 : -1;
  endfunction

  function automatic int st_at(input int i, input int t0);
    return (i < st_q.size()) ? st_q[i] - t0 : -1;
  endfunction

  // Reference timing: enables every div_eff cycles after launch, strobes at
  // the half-period count, everything stops at the burst length or when the
  // mode is dropped after w cycles.
  task automatic build_model(input logic [1:0] mode, input int d, input int len,
                             input int w, input int t0);
    int deff;
    int limit;
    deff = (d == 0) ? 1 : d;
    limit = (mode == M_BURST) ? len : 1000;
    exp_ce.delete();
    exp_st.delete();
    for (int k = 1; k <= limit && k * deff <= w; k++) exp_ce.push_back(t0 + k * deff);
    if (deff >= 4)
      for (int k = 1; k <= limit && 1 + deff / 2 + (k - 1) * deff <= w; k++)
        exp_st.push_back(t0 + 1 + deff / 2 + (k - 1) * deff);
  endtask

  task automatic run_txn(input string tag, input logic [1:0] mode, input int d,
                         input int len, input int w, input int exp_n, input int exp_s);
    int  t0;
    int  n_ce;
    int  n_st;
    bit  launched;
    ce_q.delete();
    st_q.delete();
    apply_stimulus(mode, d, len);
    pulse_start(t0);
    wait_cycles(1);
    launched = !((mode == M_BURST) && (len == 0));
    check_output({tag, " halted_after_start"}, longint'(bus.halted), longint'(!launched));
    wait_cycles(w - 1);
    bus.mode = M_HALT;
    wait_cycles(4);
    build_model(mode, d, len, w, t0);
    n_ce = (exp_n >= 0) ? exp_n : exp_ce.size();
    n_st = (exp_s >= 0) ? exp_s : exp_st.size();
    check_output({tag, " ce_count"}, ce_q.size(), n_ce);
    check_output({tag, " strobe_count"}, st_q.size(), n_st);
    for (int i = 0; i < exp_ce.size(); i++)
      check_output($sformatf("%s ce%0d_time", tag, i), ce_at(i, t0), exp_ce[i] - t0);
    for (int i = 0; i < exp_st.size(); i++)
      check_output($sformatf("%s strobe%0d_time", tag, i), st_at(i, t0), exp_st[i] - t0);
    exp_cc += n_ce;
    check_output({tag, " cycle_count"}, longint'(bus.cycle_count), exp_cc);
    check_output({tag, " halted_end"}, longint'(bus.halted), 1);
  endtask

  initial begin
    int         t0;
    int         n;
    logic [1:0] rm;
    int         rd;
    int         rl;
    int         rw;

    vecs[0] = '{M_BURST, 2, 3, 20, 3, 0};
    vecs[1] = '{M_BURST, 2, 0, 10, 0, 0};
    vecs[2] = '{M_BURST, 0, 5, 20, 5, 0};
    vecs[3] = '{M_BURST, 4, 2, 20, 2, 2};
    vecs[4] = '{M_RUN,   4, 0, 13, 3, 3};
    vecs[5] = '{M_RUN,   3, 0,  9, 3, 0};
    vecs[6] = '{M_RUN,   5, 0, 12, 2, 2};
    vecs[7] = '{M_BURST, 2, 10, 9, 4, 0};
    vecs[8] = '{M_RUN,   1, 0,  6, 6, 0};
    vecs[9] = '{M_BURST, 6, 2, 20, 2, 2};

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.step_btn = 1'b0;
    bus.bp_en    = 1'b0;
    bus.bp_addr  = '0;
    apply_stimulus(M_HALT, 0, 0);
    #1 rst = 1'b0;
    wait_cycles(2);
    check_output("reset halted", longint'(bus.halted), 1);
    check_output("reset cpu_ce", longint'(bus.cpu_ce), 0);
    check_output("reset phase_strobe", longint'(bus.phase_strobe), 0);
    check_output("reset bp_hit", longint'(bus.bp_hit), 0);
    check_output("reset cycle_count", longint'(bus.cycle_count), 0);
    rst = 1'b1;
    wait_cycles(2);

    // Run at div 4, then reset mid-run.
    $display("[TB] run with mid-run reset");
    ce_q.delete();
    st_q.delete();
    apply_stimulus(M_RUN, 4, 0);
    pulse_start(t0);
    wait_cycles(9);
    check_output("run4 ce_count", ce_q.size(), 2);
    check_output("run4 ce0_time", ce_at(0, t0), 4);
    check_output("run4 ce1_time", ce_at(1, t0), 8);
    check_output("run4 strobe0_time", st_at(0, t0), 3);
    check_output("run4 strobe1_time", st_at(1, t0), 7);
    check_output("run4 cycle_count", longint'(bus.cycle_count), 2);
    rst = 1'b0;
    #1;
    check_output("async reset cpu_ce", longint'(bus.cpu_ce), 0);
    check_output("async reset halted", longint'(bus.halted), 1);
    check_output("async reset cycle_count", longint'(bus.cycle_count), 0);
    exp_cc = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    ce_q.delete();
    wait_cycles(12);
    check_output("post reset no ce", ce_q.size(), 0);
    bus.mode = M_HALT;
    wait_cycles(2);

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].mode, vecs[i].div, vecs[i].len,
              vecs[i].w, vecs[i].exp_n, vecs[i].exp_s);

    // Single-step through the debouncer.
    $display("[TB] step debounce");
    ce_q.delete();
    apply_stimulus(M_STEP, 2, 0);
    repeat (3) begin
      bus.step_btn = 1'b1;
      wait_cycles(3);
      bus.step_btn = 1'b0;
      wait_cycles(5);
    end
    wait_cycles(15);
    check_output("step glitches no ce", ce_q.size(), 0);
    bus.step_btn = 1'b1;
    wait_cycles(20);
    check_output("step press one ce", ce_q.size(), 1);
    wait_cycles(30);
    check_output("step held no extra ce", ce_q.size(), 1);
    bus.step_btn = 1'b0;
    wait_cycles(20);
    check_output("step release no ce", ce_q.size(), 1);
    check_output("step halted", longint'(bus.halted), 1);
    exp_cc += 1;
    check_output("step cycle_count", longint'(bus.cycle_count), exp_cc);
    bus.mode = M_HALT;
    wait_cycles(2);

    // Breakpoint halt and resume from the breakpoint address.
    $display("[TB] breakpoint");
    ce_q.delete();
    bus.bp_en   = 1'b1;
    bus.bp_addr = 16'h0010;
    pc_start    = 16'h000C;
    pc_ref      = ce_total;
    apply_stimulus(M_RUN, 1, 0);
    pulse_start(t0);
    wait_cycles(2);
    n = 0;
    while (!bus.halted && n < 40) begin
      wait_cycles(1);
      n++;
    end
    check_output("bp halt reached", longint'(bus.halted), 1);
    check_output("bp ce_count", ce_q.size(), 4);
    check_output("bp bp_hit", longint'(bus.bp_hit), 1);
    check_output("bp pc", longint'(bus.cpu_pc), 16'h0010);
    exp_cc += 4;
    ce_q.delete();
    pulse_start(t0);
    check_output("bp restart clears bp_hit", longint'(bus.bp_hit), 0);
    wait_cycles(4);
    bus.mode = M_HALT;
    wait_cycles(4);
    check_output("bp resume ce_count", ce_q.size(), 4);
    check_output("bp resume ce0_time", ce_at(0, t0), 1);
    check_output("bp resume pc", longint'(bus.cpu_pc), 16'h0014);
    check_output("bp resume bp_hit", longint'(bus.bp_hit), 0);
    exp_cc += 4;
    check_output("bp cycle_count", longint'(bus.cycle_count), exp_cc);
    bus.bp_en = 1'b0;

    // Divider shrinks 8 -> 2 while the count sits at 5.
    $display("[TB] divider shrink");
    ce_q.delete();
    st_q.delete();
    apply_stimulus(M_RUN, 8, 0);
    pulse_start(t0);
    wait_cycles(5);
    bus.div_val = DIV_W'(2);
    wait_cycles(7);
    bus.mode = M_HALT;
    wait_cycles(4);
    check_output("shrink ce_count", ce_q.size(), 4);
    check_output("shrink ce0_time", ce_at(0, t0), 6);
    check_output("shrink ce1_time", ce_at(1, t0), 8);
    check_output("shrink ce3_time", ce_at(3, t0), 12);
    check_output("shrink strobe_count", st_q.size(), 1);
    check_output("shrink strobe0_time", st_at(0, t0), 5);
    exp_cc += 4;
    check_output("shrink cycle_count", longint'(bus.cycle_count), exp_cc);

    $display("[TB] randomized run/burst");
    for (int r = 0; r < 16; r++) begin
      rm = ($urandom_range(0, 1) == 0) ? M_RUN : M_BURST;
      rd = $urandom_range(0, 6);
      rl = $urandom_range(0, 5);
      rw = $urandom_range(1, 30);
      run_txn($sformatf("rnd%0d", r), rm, rd, rl, rw, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
